stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
Multi-cycle control FSM for the NPC core. It steps each instruction through IF/ID/EX/MEM/WB, handshakes with the instruction-fetch unit and the LSU, and drives the register-file, PC and IR write enables. It is the direct upstream producer of the simulation-event signals: stage code, halt, jal/jalr triggers and memory read/write enables. Every event output is a clean single-cycle registered pulse, or a sticky level, so edge-triggered consumers fire exactly once per instruction.

Parameters:
WAIT_MAX, 15, maximum cycles spent waiting for ifu_ready or mem_ready in one IF or MEM visit before an error halt (must be ≥1).
STAGE_W, 3, width of the stage code.

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
ifu_req  out  1  fetch request; high throughout IF
ifu_ready  in  1  fetch done; IFU then holds the instruction stable until the next ifu_req
dec_is_load  in  1  decoder flag, sampled in ID
dec_is_store  in  1  decoder flag, sampled in ID
dec_is_jal  in  1  decoder flag, sampled in ID
dec_is_jalr  in  1  decoder flag, sampled in ID
dec_is_ebreak  in  1  decoder flag, sampled in ID
dec_illegal  in  1  decoder flag, sampled in ID
mem_ready  in  1  LSU access complete
stage  out  STAGE_W  current stage code
ir_we  out  1  instruction-register write
inst_jal  out  1  jal event pulse
inst_jalr  out  1  jalr event pulse
memReadEnable  out  1  load-start pulse
memWriteEnable  out  1  store-start pulse
rf_we  out  1  register-file write
pc_we  out  1  PC update
halt  out  1  sticky halt
halt_code  out  2  0 = ebreak, 1 = illegal, 2 = IF timeout, 3 = MEM timeout

Behaviour:
- Reset (synchronous, active-high, dominant over everything):
  - stage = IF; halt = 0; halt_code = 0.
  - All pulse outputs = 0; captured decode flags cleared; wait counter = 0.
  - A reset mid-operation (any state, including HALT or MEM waiting) gives IF on the next cycle. No pulse is emitted in the reset cycle.
- Output timing:
  - All outputs are Moore, decoded from registered state plus registered flags only.
  - No combinational path from any input to any output.
- IF (0):
  - ifu_req = 1.
  - ifu_ready = 1 moves to ID next cycle.
  - Otherwise wcnt increments. When wcnt == WAIT_MAX with ifu_ready still 0, go to HALT with code 2.
- ID (1), always 1 cycle:
  - ir_we = 1; all dec_* flags registered at the end of the cycle.
  - Priority: illegal, or load and store both set → HALT code 1; then ebreak → HALT code 0; else EX.
- EX (2), always 1 cycle:
  - inst_jal = jal_q; inst_jalr = jalr_q (jal and jalr both set is treated as illegal in ID).
  - Next state is MEM if load_q or store_q, else WB.
- MEM (3):
  - memReadEnable = load_q and memWriteEnable = store_q, in the first MEM cycle only.
  - mem_ready is sampled every MEM cycle, including the first. mem_ready = 1 moves to WB.
  - Timeout rules as in IF, with code 3.
  - Enables are never re-asserted while waiting.
- WB (4), always 1 cycle:
  - pc_we = 1; rf_we = !store_q. Next state is IF.
- HALT (5):
  - halt = 1 and halt_code hold until reset; ifu_req = 0; no further pulses.
- wcnt:
  - Width is clog2(WAIT_MAX+1). Cleared on every state entry; saturates.
- Minimum latency (ready inputs high immediately):
  - Non-memory instruction: 4 cycles, IF→ID→EX→WB.
  - Memory instruction: 5 cycles.
- Unused codes 6 and 7 are unreachable. If reached, the FSM goes to IF.

Decomposition:
- Package npc_stage_pkg holds:
  - the stage_t enum (IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5) and STAGE_W;
  - the halt-code localparams (HALT_EBREAK, HALT_ILLEGAL, HALT_IF_TMO, HALT_MEM_TMO).
- One sub-module, wait_timer: a saturating counter with clear and an expired flag, instantiated once and shared by IF and MEM (the two states are never active together).

Test Plan:
- ALU instruction, ifu_ready tied high: stage = 0,1,2,4,0 on consecutive cycles; ir_we high only in cycle 1; rf_we = pc_we = 1 only in cycle 3; no event pulses.
- Load, mem_ready asserted on the 3rd MEM cycle: memReadEnable high for exactly 1 cycle (the first MEM cycle); WB follows the cycle after mem_ready; rf_we = 1.
- Store with mem_ready already high on MEM entry: memWriteEnable 1-cycle pulse, one MEM cycle; WB has rf_we = 0 and pc_we = 1.
- jal then jalr back-to-back: exactly one inst_jal pulse in the first instruction's EX and one inst_jalr pulse in the second's EX; never both high together.
- ebreak in ID: stage = 5 next cycle; halt = 1 and halt_code = 0 held for 20+ cycles; ifu_req stays 0. Illegal flag instead gives halt_code = 1.
- WAIT_MAX = 4, load with mem_ready held 0: HALT with code 3 after 4 wait cycles. Reset asserted mid-MEM in a separate run: the next cycle shows stage = 0, all pulses 0, halt = 0.

Source files
------------

// File: rtl/npc_stage_pkg.sv
// Stage codes, halt codes and shared widths for the NPC multi-cycle stage sequencer.
package npc_stage_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } stage_t;

  localparam logic [1:0] HALT_EBREAK  = 2'd0;
  localparam logic [1:0] HALT_ILLEGAL = 2'd1;
  localparam logic [1:0] HALT_IF_TMO  = 2'd2;
  localparam logic [1:0] HALT_MEM_TMO = 2'd3;

endpackage

// File: rtl/wait_timer.sv
// Saturating wait counter with synchronous clear; o_expired is high while the count sits at MAX.
module wait_timer #(
  parameter int MAX = 15,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != W'(MAX))) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count   = r_count;
  assign o_expired = (r_count == W'(MAX));

endmodule

// File: rtl/stage_sequencer.sv
// IF/ID/EX/MEM/WB control FSM; every output is decoded from registered state and captured decode flags.
module stage_sequencer
  import npc_stage_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic               clock,
  input  logic               reset,
  output logic               ifu_req,
  input  logic               ifu_ready,
  input  logic               dec_is_load,
  input  logic               dec_is_store,
  input  logic               dec_is_jal,
  input  logic               dec_is_jalr,
  input  logic               dec_is_ebreak,
  input  logic               dec_illegal,
  input  logic               mem_ready,
  output logic [STAGE_W-1:0] stage,
  output logic               ir_we,
  output logic               inst_jal,
  output logic               inst_jalr,
  output logic               memReadEnable,
  output logic               memWriteEnable,
  output logic               rf_we,
  output logic               pc_we,
  output logic               halt,
  output logic [1:0]         halt_code
);

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);

  stage_t            r_state;
  stage_t            w_next;
  logic [1:0]        r_halt_code;
  logic [1:0]        w_halt_code;
  logic              r_load_q;
  logic              r_store_q;
  logic              r_jal_q;
  logic              r_jalr_q;
  logic [WCNT_W-1:0] w_wcnt;
  logic              w_expired;
  logic              w_waiting;
  logic              w_ready;
  logic              w_clr;

  // IF and MEM are never active together, so one timer serves both.
  assign w_waiting = (r_state == S_IF) || (r_state == S_MEM);
  assign w_ready   = (r_state == S_IF) ? ifu_ready : mem_ready;
  assign w_clr     = (w_next != r_state);

  wait_timer #(
    .MAX (WAIT_MAX),
    .W   (WCNT_W)
  ) u_wait_timer (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_clr     (w_clr),
    .i_inc     (w_waiting && !w_ready),
    .o_count   (w_wcnt),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IF;
      r_halt_code <= HALT_EBREAK;
      r_load_q    <= 1'b0;
      r_store_q   <= 1'b0;
      r_jal_q     <= 1'b0;
      r_jalr_q    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_halt_code <= w_halt_code;
      if (r_state == S_ID) begin
        r_load_q  <= dec_is_load;
        r_store_q <= dec_is_store;
        r_jal_q   <= dec_is_jal;
        r_jalr_q  <= dec_is_jalr;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_halt_code = r_halt_code;
    case (r_state)
      S_IF: begin
        if (ifu_ready) begin
          w_next = S_ID;
        end else if (w_expired) begin
          w_next      = S_HALT;
          w_halt_code = HALT_IF_TMO;
        end
      end
      S_ID: begin
        // Conflicting access or branch kinds are undecodable and rank with illegal.
        if (dec_illegal || (dec_is_load && dec_is_store) || (dec_is_jal && dec_is_jalr)) begin
          w_next      = S_HALT;
          w_halt_code = HALT_ILLEGAL;
        end else if (dec_is_ebreak) begin
          w_next      = S_HALT;
          w_halt_code = HALT_EBREAK;
        end else begin
          w_next = S_EX;
        end
      end
      S_EX:  w_next = (r_load_q || r_store_q) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready) begin
          w_next = S_WB;
        end else if (w_expired) begin
          w_next      = S_HALT;
          w_halt_code = HALT_MEM_TMO;
        end
      end
      S_WB:    w_next = S_IF;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  // The wait count is still zero only in the first cycle of a MEM visit.
  assign ifu_req        = (r_state == S_IF);
  assign ir_we          = (r_state == S_ID);
  assign inst_jal       = (r_state == S_EX) && r_jal_q;
  assign inst_jalr      = (r_state == S_EX) && r_jalr_q;
  assign memReadEnable  = (r_state == S_MEM) && (w_wcnt == '0) && r_load_q;
  assign memWriteEnable = (r_state == S_MEM) && (w_wcnt == '0) && r_store_q;
  assign rf_we          = (r_state == S_WB) && !r_store_q;
  assign pc_we          = (r_state == S_WB);
  assign halt           = (r_state == S_HALT);
  assign halt_code      = r_halt_code;
  assign stage          = r_state;

endmodule

// File: tb/tb_stage_sequencer.sv
// Instruction-level plan expanded into a per-cycle expectation queue; checked against the sequencer every cycle.
module tb_stage_sequencer;

  localparam int WM = 4;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_JAL = 3, K_JALR = 4, K_EBREAK = 5;
  localparam int K_ILL = 6, K_LDST = 7, K_JJ = 8, K_EBI = 9;

  typedef struct {
    bit       rst;
    bit       ifr;
    bit       mr;
    bit [5:0] dec;   // load, store, jal, jalr, ebreak, illegal (bit 0 upward)
    int       stg;
    bit       req, irwe, jal, jalr, mre, mwe, rf, pc, hlt;
    int       code;
  } cyc_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ifu_ready = 1'b0, mem_ready = 1'b0;
  logic       dec_is_load = 1'b0, dec_is_store = 1'b0, dec_is_jal = 1'b0;
  logic       dec_is_jalr = 1'b0, dec_is_ebreak = 1'b0, dec_illegal = 1'b0;
  logic       ifu_req, ir_we, inst_jal, inst_jalr, memReadEnable, memWriteEnable;
  logic       rf_we, pc_we, halt;
  logic [2:0] stage;
  logic [1:0] halt_code;

  cyc_t q[$];
  int   stage_log[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_pin[16] = '{0, 1, 2, 4, 0, 1, 2, 3, 3, 3, 4, 0, 1, 2, 3, 4};

  stage_sequencer #(.WAIT_MAX(WM)) dut (
    .clock          (clock),
    .reset          (reset),
    .ifu_req        (ifu_req),
    .ifu_ready      (ifu_ready),
    .dec_is_load    (dec_is_load),
    .dec_is_store   (dec_is_store),
    .dec_is_jal     (dec_is_jal),
    .dec_is_jalr    (dec_is_jalr),
    .dec_is_ebreak  (dec_is_ebreak),
    .dec_illegal    (dec_illegal),
    .mem_ready      (mem_ready),
    .stage          (stage),
    .ir_we          (ir_we),
    .inst_jal       (inst_jal),
    .inst_jalr      (inst_jalr),
    .memReadEnable  (memReadEnable),
    .memWriteEnable (memWriteEnable),
    .rf_we          (rf_we),
    .pc_we          (pc_we),
    .halt           (halt),
    .halt_code      (halt_code)
  );

  always #5 clock = ~clock;

  // Inputs that the current stage ignores are randomised on purpose.
  function automatic cyc_t blank(input int stg);
    cyc_t c;
    c.rst  = 1'b0;
    c.ifr  = 1'($urandom_range(0, 1));
    c.mr   = 1'($urandom_range(0, 1));
    c.dec  = 6'($urandom);
    c.stg  = stg;
    c.req  = (stg == 0);
    c.irwe = 0; c.jal = 0; c.jalr = 0; c.mre = 0; c.mwe = 0;
    c.rf   = 0; c.pc = 0; c.hlt = 0;
    c.code = 0;
    return c;
  endfunction

  task automatic push_halt(input int code, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c      = blank(5);
      c.req  = 0;
      c.hlt  = 1;
      c.code = code;
      c.rst  = (i == n - 1);
      q.push_back(c);
    end
  endtask

  // Expand one instruction into expected cycles; rst_at > 0 aborts MEM with a reset at that MEM cycle.
  task automatic plan(input int kind, input int if_d, input int mem_d, input int rst_at, input int hlen);
    cyc_t c;
    bit   ld, st;
    ld = (kind == K_LOAD);
    st = (kind == K_STORE);
    for (int k = 0; k <= WM; k++) begin
      c     = blank(0);
      c.ifr = (k >= if_d);
      q.push_back(c);
      if (c.ifr) break;
      if (k == WM) begin
        push_halt(2, hlen);
        return;
      end
    end
    c      = blank(1);
    c.irwe = 1;
    case (kind)
      K_LOAD:   c.dec = 6'b000001;
      K_STORE:  c.dec = 6'b000010;
      K_JAL:    c.dec = 6'b000100;
      K_JALR:   c.dec = 6'b001000;
      K_EBREAK: c.dec = 6'b010000;
      K_ILL:    c.dec = 6'b100000 | 6'($urandom);
      K_LDST:   c.dec = 6'b000011;
      K_JJ:     c.dec = 6'b001100;
      K_EBI:    c.dec = 6'b110000;
      default:  c.dec = 6'b000000;
    endcase
    q.push_back(c);
    if (kind == K_ILL || kind == K_LDST || kind == K_JJ || kind == K_EBI) begin
      push_halt(1, hlen);
      return;
    end
    if (kind == K_EBREAK) begin
      push_halt(0, hlen);
      return;
    end
    c      = blank(2);
    c.jal  = (kind == K_JAL);
    c.jalr = (kind == K_JALR);
    q.push_back(c);
    if (ld || st) begin
      for (int k = 0; k <= WM; k++) begin
        c     = blank(3);
        c.mr  = (k >= mem_d);
        c.mre = ld && (k == 0);
        c.mwe = st && (k == 0);
        if (rst_at > 0 && k == rst_at) begin
          c.rst = 1;
          c.mr  = 0;
          q.push_back(c);
          return;
        end
        q.push_back(c);
        if (c.mr) break;
        if (k == WM) begin
          push_halt(3, hlen);
          return;
        end
      end
    end
    c    = blank(4);
    c.pc = 1;
    c.rf = !st;
    q.push_back(c);
  endtask

  task automatic chk(input string name, input int cyc, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  initial begin
    cyc_t c;
    int   r, ifd, md;

    // Directed opening: ALU, load (ready on 3rd MEM cycle), store (ready at once), jal, jalr.
    plan(K_ALU, 0, 0, 0, 1);
    plan(K_LOAD, 0, 2, 0, 1);
    plan(K_STORE, 0, 0, 0, 1);
    plan(K_JAL, 0, 0, 0, 1);
    plan(K_JALR, 0, 0, 0, 1);
    plan(K_EBREAK, 1, 0, 0, 22);
    plan(K_ILL, 0, 0, 0, 3);
    plan(K_LOAD, 0, WM + 3, 0, 3);
    plan(K_ALU, WM + 2, 0, 0, 3);
    plan(K_LOAD, 0, WM + 3, 2, 1);
    plan(K_STORE, 2, 1, 0, 1);

    for (int n = 0; n < 300; n++) begin
      r   = $urandom_range(0, 99);
      ifd = ($urandom_range(0, 19) == 0) ? WM + 1 : $urandom_range(0, 3);
      md  = ($urandom_range(0, 19) == 0) ? WM + 1 : $urandom_range(0, 3);
      if      (r < 30) plan(K_ALU,    ifd, md, 0, $urandom_range(1, 4));
      else if (r < 45) plan(K_LOAD,   ifd, md, 0, $urandom_range(1, 4));
      else if (r < 60) plan(K_STORE,  ifd, md, 0, $urandom_range(1, 4));
      else if (r < 70) plan(K_JAL,    ifd, md, 0, $urandom_range(1, 4));
      else if (r < 80) plan(K_JALR,   ifd, md, 0, $urandom_range(1, 4));
      else if (r < 84) plan(K_EBREAK, ifd, md, 0, $urandom_range(1, 4));
      else if (r < 88) plan(K_ILL,    ifd, md, 0, $urandom_range(1, 4));
      else if (r < 90) plan(K_LDST,   ifd, md, 0, $urandom_range(1, 4));
      else if (r < 92) plan(K_JJ,     ifd, md, 0, $urandom_range(1, 4));
      else if (r < 94) plan(K_EBI,    ifd, md, 0, $urandom_range(1, 4));
      else             plan(K_LOAD,   0, WM + 2, $urandom_range(1, WM), 1);
    end

    reset = 1'b1;
    repeat (3) @(posedge clock);

    for (int i = 0; i < q.size(); i++) begin
      c = q[i];
      @(negedge clock);
      stage_log.push_back(int'(stage));
      chk("stage",          i, int'(stage),          c.stg);
      chk("ifu_req",        i, int'(ifu_req),        int'(c.req));
      chk("ir_we",          i, int'(ir_we),          int'(c.irwe));
      chk("inst_jal",       i, int'(inst_jal),       int'(c.jal));
      chk("inst_jalr",      i, int'(inst_jalr),      int'(c.jalr));
      chk("memReadEnable",  i, int'(memReadEnable),  int'(c.mre));
      chk("memWriteEnable", i, int'(memWriteEnable), int'(c.mwe));
      chk("rf_we",          i, int'(rf_we),          int'(c.rf));
      chk("pc_we",          i, int'(pc_we),          int'(c.pc));
      chk("halt",           i, int'(halt),           int'(c.hlt));
      chk("halt_code",      i, int'(halt_code),      c.code);
      reset         = c.rst;
      ifu_ready     = c.ifr;
      mem_ready     = c.mr;
      dec_is_load   = c.dec[0];
      dec_is_store  = c.dec[1];
      dec_is_jal    = c.dec[2];
      dec_is_jalr   = c.dec[3];
      dec_is_ebreak = c.dec[4];
      dec_illegal   = c.dec[5];
    end

    // Hand-derived stage trace of the first three directed instructions.
    for (int i = 0; i < 16; i++) begin
      chk("pinned_stage", i, stage_log[i], exp_pin[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
